// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller is the master: it consumes Opcode/mem_ready and drives every control line.
interface multicycle_controller_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       IorD;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALU_op;
  logic [1:0] PCSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       Branch;
  logic       BranchNE;
  logic       MemWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  Opcode, mem_ready,
    output IorD, ALUSrcA, ALUSrcB, ALU_op, PCSrc, IRWrite, PCWrite, Branch, BranchNE,
           MemWrite, RegWrite, RegDst, MemtoReg, instr_done, illegal_op, state
  );

  modport slave (
    output Opcode, mem_ready,
    input  IorD, ALUSrcA, ALUSrcB, ALU_op, PCSrc, IRWrite, PCWrite, Branch, BranchNE,
           MemWrite, RegWrite, RegDst, MemtoReg, instr_done, illegal_op, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style main control FSM for a MIPS-like multicycle datapath, with an optional
// memory ready handshake and optional bne support.
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ENABLE_BNE    = 1'b0
) (
  input logic                     clk,
  input logic                     rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_BNE     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state_q;
  state_t state_d;
  logic   mem_ok;
  logic   op_legal;

  assign mem_ok    = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
  assign bus.state = state_q;

  always_comb begin : legal_decode
    // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
    op_legal = 1'b0;
    case (bus.Opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      OP_BNE:                                       op_legal = ENABLE_BNE;
      default:                                      op_legal = 1'b0;
    endcase
  end

  always_comb begin : next_state
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = ENABLE_BNE ? S_BNE : S_FETCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ok ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ok ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin : decode_outputs
    bus.IorD       = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ALU_op     = 2'b00;
    bus.PCSrc      = 2'b00;
    bus.IRWrite    = 1'b0;
    bus.PCWrite    = 1'b0;
    bus.Branch     = 1'b0;
    bus.BranchNE   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.RegDst     = 1'b0;
    bus.MemtoReg   = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal_op = 1'b0;
    case (state_q)
      // Reset parks the FSM in FETCH, so rst must also mask the fetch write enables.
      S_FETCH: begin
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = mem_ok & ~rst;
        bus.PCWrite = mem_ok & ~rst;
      end
      S_DECODE: begin
        bus.ALUSrcB    = 2'b11;
        bus.illegal_op = ~op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: bus.IorD = 1'b1;
      S_MEMWB: begin
        bus.RegWrite   = 1'b1;
        bus.MemtoReg   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD       = 1'b1;
        bus.MemWrite   = 1'b1;
        bus.instr_done = mem_ok;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALU_op  = 2'b10;
      end
      S_ALUWB: begin
        bus.RegDst     = 1'b1;
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        bus.RegWrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALU_op     = 2'b01;
        bus.PCSrc      = 2'b01;
        bus.Branch     = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BNE: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALU_op     = 2'b01;
        bus.PCSrc      = 2'b01;
        bus.BranchNE   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.PCSrc      = 2'b10;
        bus.PCWrite    = 1'b1;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1, where 1 means memory states wait on mem_ready and 0 means mem_ready is ignored (treated as 1).
REQ-002 SHALL have parameter ENABLE_BNE, default 0, where 1 means opcode 6'b000101 (bne) is decoded and 0 means it is illegal.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction opcode, sampled in DECODE.
- mem_ready  in  1  memory access complete this cycle.
- IorD  out  1  memory address select (0=PC, 1=ALUOut).
- ALUSrcA  out  1  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ALU_op  out  2  ALU decoder opcode.
- PCSrc  out  2  next-PC select.
- IRWrite  out  1  instruction register load enable.
- PCWrite  out  1  unconditional PC write.
- Branch  out  1  beq branch enable.
- BranchNE  out  1  bne branch enable.
- MemWrite  out  1  data memory write.
- RegWrite  out  1  register file write.
- RegDst  out  1  write register select.
- MemtoReg  out  1  write-back data select.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- state  out  4  current state code, for debug.

Function
REQ-004 SHALL be a Moore FSM; every output SHALL be combinational from state only, except the mem_ready gating in REQ-007.
REQ-005 SHALL use these states and transitions:
- FETCH=0 -> DECODE.
- DECODE=1 -> MEMADR for lw (100011) or sw (101011); EXECUTE for R-type (000000); ADDIEX for addi (001000); BEQ for beq (000100); BNE for 000101 when ENABLE_BNE=1; JUMP for j (000010); else FETCH.
- MEMADR=2 -> MEMRD for lw, MEMWR for sw, using Opcode held stable by the IR.
- MEMRD=3 -> MEMWB.
- MEMWB=4, MEMWR=5, ALUWB=7, BEQ=8, ADDIWB=10, JUMP=11, BNE=12 -> FETCH.
- EXECUTE=6 -> ALUWB.
- ADDIEX=9 -> ADDIWB.
REQ-006 Output values per state; any output not listed SHALL be 0:
- FETCH: ALUSrcB=01; IRWrite and PCWrite per REQ-007.
- DECODE: ALUSrcB=11.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: IorD=1, MemWrite=1.
- EXECUTE: ALUSrcA=1, ALU_op=10.
- ALUWB: RegDst=1, RegWrite=1.
- ADDIWB: RegWrite=1.
- BEQ: ALUSrcA=1, ALU_op=01, PCSrc=01, Branch=1.
- BNE: ALUSrcA=1, ALU_op=01, PCSrc=01, BranchNE=1.
- JUMP: PCSrc=10, PCWrite=1.
REQ-007 Memory handshake when MEM_HANDSHAKE=1:
- FETCH, MEMRD and MEMWR SHALL hold their state while mem_ready=0 and advance on the edge where mem_ready=1.
- IRWrite and PCWrite in FETCH SHALL equal mem_ready.
- MemWrite SHALL stay at 1 for the whole MEMWR wait.
REQ-008 With MEM_HANDSHAKE=0, every state SHALL advance each cycle, and IRWrite=PCWrite=1 in FETCH.
REQ-009 instr_done SHALL be 1 in:
- MEMWB, ALUWB, ADDIWB, BEQ, BNE and JUMP;
- MEMWR only when mem_ready (or MEM_HANDSHAKE=0).
REQ-010 illegal_op SHALL be 1 in DECODE when Opcode is unsupported, including bne when ENABLE_BNE=0; the FSM SHALL then return to FETCH without any write enable asserted.
REQ-011 Cycles per instruction with zero wait states SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, bne 3, j 3.
REQ-012 Unused state codes 13-15 SHALL transition to FETCH on the next edge, with all outputs 0.

Reset
REQ-013 rst=1 SHALL force state=FETCH immediately, without waiting for clk.
REQ-014 While rst=1, IRWrite, PCWrite, MemWrite, RegWrite, Branch, BranchNE, instr_done and illegal_op SHALL be 0; mux selects SHALL take their FETCH values.
REQ-015 Reset asserted mid-instruction, including during a MEMWR wait, SHALL abort the instruction; MemWrite SHALL drop within the same cycle.
REQ-016 After rst deasserts, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-017 lw, mem_ready=1: state sequence SHALL be 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4; instr_done pulses once.
REQ-018 sw with mem_ready low for 3 cycles in MEMWR: MemWrite=1 for 4 cycles, then return to FETCH; instr_done only in the ready cycle.
REQ-019 FETCH with mem_ready low for 2 cycles: IRWrite=PCWrite=0 for 2 cycles, then 1 for one cycle, then DECODE.
REQ-020 Opcode 000101:
- ENABLE_BNE=0: illegal_op pulse in DECODE, next state FETCH.
- ENABLE_BNE=1: state 12 with BranchNE=1, PCSrc=01.
REQ-021 rst asserted asynchronously mid-cycle in MEMWR: state=0 and MemWrite=0 before the next clk edge.
REQ-022 R-type, j and addi back to back, zero wait: states 0,1,6,7,0,1,11,0,1,9,10; instr_done pulses 3 times.
